// File: rtl/airlock_interlock.sv
// rtl/airlock_interlock.sv - two-door airlock sequencer with pump timer and sticky interlock alarm
// Outputs are registered from the current state, so they trail the state register by one clock.
module airlock_interlock #(
  parameter int PUMP_CYCLES = 5,
  parameter int CNT_W       = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       Key1,
  input  logic       Key2,
  output logic       InnerOpen,
  output logic       OuterOpen,
  output logic       Pressurized,
  output logic       Pumping,
  output logic       Alarm,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    PRESS_IDLE     = 3'd0,
    INNER_OPEN     = 3'd1,
    DEPRESSURIZING = 3'd2,
    VAC_IDLE       = 3'd3,
    OUTER_OPEN     = 3'd4,
    PRESSURIZING   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PUMP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             key1q;
  logic             key2q;
  logic             key1_press;
  logic             key2_press;
  logic             pump_state;
  logic             press_side;
  logic             vac_side;
  logic             violation;
  logic             pump_go;

  // Falling-edge detect: a held key yields a single press.
  assign key1_press = key1q & ~Key1;
  assign key2_press = key2q & ~Key2;

  assign pump_state = (state == DEPRESSURIZING) || (state == PRESSURIZING);
  assign press_side = (state == PRESS_IDLE) || (state == INNER_OPEN);
  assign vac_side   = (state == VAC_IDLE) || (state == OUTER_OPEN);
  assign violation  = (SW2 & (press_side | pump_state))
                    | (SW3 & (vac_side | pump_state))
                    | (SW2 & SW3);
  assign pump_go    = SW0 & ~SW2 & ~SW3;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= PRESS_IDLE;
      cnt         <= '0;
      key1q       <= 1'b1;
      key2q       <= 1'b1;
      State       <= 3'd0;
      InnerOpen   <= 1'b0;
      OuterOpen   <= 1'b0;
      Pressurized <= 1'b1;
      Pumping     <= 1'b0;
      Alarm       <= 1'b0;
    end else begin
      key1q       <= Key1;
      key2q       <= Key2;
      State       <= state;
      InnerOpen   <= (state == INNER_OPEN);
      OuterOpen   <= (state == OUTER_OPEN);
      Pressurized <= press_side;
      Pumping     <= pump_state & ~SW1;
      Alarm       <= Alarm | violation;

      case (state)
        PRESS_IDLE: begin
          if (SW3 && !SW2) begin
            state <= INNER_OPEN;
          end else if (key2_press && pump_go) begin
            state <= DEPRESSURIZING;
            cnt   <= '0;
          end
        end
        INNER_OPEN: begin
          if (!SW3) state <= PRESS_IDLE;
        end
        DEPRESSURIZING, PRESSURIZING: begin
          // SW1 freezes the pump: no count, no exit.
          if (!SW1) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= (state == DEPRESSURIZING) ? VAC_IDLE : PRESS_IDLE;
            end
          end
        end
        VAC_IDLE: begin
          if (SW2 && !SW3) begin
            state <= OUTER_OPEN;
          end else if (key1_press && pump_go) begin
            state <= PRESSURIZING;
            cnt   <= '0;
          end
        end
        OUTER_OPEN: begin
          if (!SW2) state <= VAC_IDLE;
        end
        default: state <= PRESS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_airlock_interlock.sv
// tb/tb_airlock_interlock.sv - directed bench for airlock_interlock with a chamber-level reference model
module tb_airlock_interlock;

  localparam int PUMP_CYCLES = 5;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       SW0 = 1'b0;
  logic       SW1 = 1'b0;
  logic       SW2 = 1'b0;
  logic       SW3 = 1'b0;
  logic       Key1 = 1'b1;
  logic       Key2 = 1'b1;
  logic       InnerOpen;
  logic       OuterOpen;
  logic       Pressurized;
  logic       Pumping;
  logic       Alarm;
  logic [2:0] State;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  int cyc = 0;
  int pump_hi = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  airlock_interlock #(.PUMP_CYCLES(PUMP_CYCLES), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset),
    .SW0(SW0), .SW1(SW1), .SW2(SW2), .SW3(SW3),
    .Key1(Key1), .Key2(Key2),
    .InnerOpen(InnerOpen), .OuterOpen(OuterOpen), .Pressurized(Pressurized),
    .Pumping(Pumping), .Alarm(Alarm), .State(State)
  );

  always #5 Clock = ~Clock;

  // Chamber model: which side the air is on, which door is open, pump cycles remaining.
  bit m_press, m_inner, m_outer, m_to_press, m_k1prev, m_k2prev;
  int m_left;
  int exp_state;
  bit exp_inner, exp_outer, exp_pressurized, exp_pumping, exp_alarm;

  always @(posedge Clock or posedge Reset) begin
    bit pumping, viol, p1, p2, go;
    if (Reset) begin
      m_press = 1; m_inner = 0; m_outer = 0; m_to_press = 0;
      m_k1prev = 1; m_k2prev = 1; m_left = 0;
      exp_state = 0; exp_inner = 0; exp_outer = 0;
      exp_pressurized = 1; exp_pumping = 0; exp_alarm = 0;
    end else begin
      pumping = (m_left > 0);
      if (pumping)      exp_state = m_to_press ? 5 : 2;
      else if (m_inner) exp_state = 1;
      else if (m_outer) exp_state = 4;
      else              exp_state = m_press ? 0 : 3;
      exp_inner       = m_inner;
      exp_outer       = m_outer;
      exp_pressurized = !pumping && m_press;
      exp_pumping     = pumping && !SW1;
      viol = (SW2 && SW3) || (pumping && (SW2 || SW3))
          || (!pumping && m_press && SW2) || (!pumping && !m_press && SW3);
      if (viol) exp_alarm = 1;

      p1 = m_k1prev && !Key1;
      p2 = m_k2prev && !Key2;
      go = SW0 && !SW2 && !SW3;
      if (pumping) begin
        if (!SW1) begin
          m_left = m_left - 1;
          if (m_left == 0) m_press = m_to_press;
        end
      end else if (m_inner) begin
        if (!SW3) m_inner = 0;
      end else if (m_outer) begin
        if (!SW2) m_outer = 0;
      end else if (m_press) begin
        if (SW3 && !SW2) m_inner = 1;
        else if (p2 && go) begin m_left = PUMP_CYCLES; m_to_press = 0; end
      end else begin
        if (SW2 && !SW3) m_outer = 1;
        else if (p1 && go) begin m_left = PUMP_CYCLES; m_to_press = 1; end
      end
      m_k1prev = Key1;
      m_k2prev = Key2;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("model_state", State, exp_state);
    chk("model_inner", InnerOpen, exp_inner);
    chk("model_outer", OuterOpen, exp_outer);
    chk("model_pressurized", Pressurized, exp_pressurized);
    chk("model_pumping", Pumping, exp_pumping);
    chk("model_alarm", Alarm, exp_alarm);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clock);
      cyc++;
      if (check_en) compare_all();
      if (Pumping === 1'b1) begin
        pump_hi++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
  endtask

  task automatic clear_pump_stats();
    pump_hi = 0; first_cyc = -1; last_cyc = -1;
  endtask

  // Called just after a falling edge; reset lands mid-cycle to exercise the async path.
  task automatic do_reset();
    #2 Reset = 1'b1;
    #1;
    compare_all();
    chk("rst_state", State, 0);
    chk("rst_pumping", Pumping, 0);
    chk("rst_pressurized", Pressurized, 1);
    chk("rst_alarm", Alarm, 0);
    step(2);
    Reset = 1'b0;
  endtask

  initial begin
    step(2);
    Reset = 1'b0;
    check_en = 1'b1;
    step(1);
    chk("reset_state", State, 0);
    chk("reset_pressurized", Pressurized, 1);
    chk("reset_doors", {InnerOpen, OuterOpen}, 0);
    chk("reset_alarm", Alarm, 0);

    SW3 = 1; step(2);
    chk("inner_open", InnerOpen, 1);
    chk("inner_state", State, 1);
    SW3 = 0; step(2);
    chk("inner_closed_state", State, 0);

    // Depressurize: key held for three cycles is one press.
    SW0 = 1; Key2 = 0; clear_pump_stats();
    step(3);
    Key2 = 1; step(8);
    chk("depress_pump_cycles", pump_hi, 5);
    chk("vac_state", State, 3);
    chk("vac_pressurized", Pressurized, 0);
    SW2 = 1; step(2);
    chk("outer_open", OuterOpen, 1);
    SW2 = 0; step(2);
    chk("outer_closed_state", State, 3);

    // Pressurize with a two-cycle hold in the middle.
    Key1 = 0; clear_pump_stats();
    step(1);
    Key1 = 1; step(1);
    SW1 = 1; step(2);
    SW1 = 0; step(8);
    chk("press_pump_cycles", pump_hi, 5);
    chk("press_pump_span", last_cyc - first_cyc + 1, 7);
    chk("press_state", State, 0);
    chk("press_pressurized", Pressurized, 1);

    // Outer request on the pressurized side: no door, sticky alarm.
    SW2 = 1; step(1);
    SW2 = 0; step(1);
    chk("viol_outer_closed", OuterOpen, 0);
    chk("viol_alarm", Alarm, 1);
    step(4);
    chk("viol_alarm_sticky", Alarm, 1);
    SW2 = 1; SW3 = 1; step(2);
    chk("both_doors_state", State, 0);
    chk("both_doors_inner", InnerOpen, 0);
    SW2 = 0; SW3 = 0;
    do_reset();
    step(1);
    chk("alarm_cleared", Alarm, 0);

    // Ignored presses: pump disabled, then wrong direction.
    SW0 = 0; Key2 = 0; step(1);
    Key2 = 1; step(1);
    SW0 = 1; Key1 = 0; step(1);
    Key1 = 1; step(3);
    chk("ignored_state", State, 0);
    chk("ignored_alarm", Alarm, 0);

    // Both keys together in PRESS_IDLE: Key2 wins; reset at pump cycle 3.
    Key1 = 0; Key2 = 0; clear_pump_stats();
    step(1);
    Key1 = 1; Key2 = 1; step(3);
    chk("both_keys_state", State, 2);
    chk("pump_before_abort", pump_hi, 3);
    do_reset();
    Key2 = 0; clear_pump_stats();
    step(1);
    Key2 = 1; step(8);
    chk("restart_pump_cycles", pump_hi, 5);
    chk("restart_state", State, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/airlock_interlock.md
# airlock_interlock

- Airlock controller that the interlock stimulus bench drives; this block is the receiving end of the same switch/key interface.
- Sequences a two-door chamber between a pressurized cabin (inner door) and vacuum (outer door).
- Only one door may be open at a time, and a door may open only when the chamber pressure matches its side.
- Pump operations take a fixed number of cycles.
- All outputs are registered (Moore) and drive board LEDs directly.

## Interface

- PUMP_CYCLES, 5, cycles spent in PRESSURIZING or DEPRESSURIZING (≥1)
- CNT_W, 8, pump counter width; PUMP_CYCLES must fit in CNT_W bits

- Clock  in  1  system clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high; one clock, no other clock domains
- SW0  in  1  pump enable; Key1/Key2 presses are ignored while 0
- SW1  in  1  pump hold; while 1, the pump counter freezes
- SW2  in  1  outer door request (1 = open, 0 = close)
- SW3  in  1  inner door request (1 = open, 0 = close)
- Key1  in  1  pressurize button, active-low (pressed = 0)
- Key2  in  1  depressurize button, active-low (pressed = 0)
- InnerOpen  out  1  inner door actuator
- OuterOpen  out  1  outer door actuator
- Pressurized  out  1  chamber at cabin pressure
- Pumping  out  1  pump running (PRESSURIZING/DEPRESSURIZING and SW1=0)
- Alarm  out  1  sticky interlock-violation flag
- State  out  3  state code for LED display

## Operation

- Key edge detect: Key1q/Key2q register the keys; a press = q==1 && key==0, giving one-cycle recognition on the falling edge only. Holding a key low gives exactly one press.
- State codes: PRESS_IDLE=0, INNER_OPEN=1, DEPRESSURIZING=2, VAC_IDLE=3, OUTER_OPEN=4, PRESSURIZING=5.
- PRESS_IDLE → INNER_OPEN when SW3=1 and SW2=0.
- PRESS_IDLE → DEPRESSURIZING on a Key2 press with SW0=1, SW2=0, SW3=0; counter loads 0.
- INNER_OPEN → PRESS_IDLE when SW3=0.
- DEPRESSURIZING: counter increments each cycle SW1=0. When counter==PUMP_CYCLES-1 with SW1=0 → VAC_IDLE.
- VAC_IDLE → OUTER_OPEN when SW2=1 and SW3=0.
- VAC_IDLE → PRESSURIZING on a Key1 press with SW0=1, SW2=0, SW3=0.
- OUTER_OPEN → VAC_IDLE when SW2=0.
- PRESSURIZING: same counting as DEPRESSURIZING, then → PRESS_IDLE.
- Outputs per state:
  - InnerOpen=1 only in INNER_OPEN.
  - OuterOpen=1 only in OUTER_OPEN.
  - Pressurized=1 in PRESS_IDLE and INNER_OPEN.
- Alarm sets and stays set until Reset on any of:
  - SW2=1 while in PRESS_IDLE or INNER_OPEN, or during pumping;
  - SW3=1 while in VAC_IDLE or OUTER_OPEN, or during pumping;
  - SW2=1 and SW3=1 together in any state.
- A violating request never opens a door.
- Wrong-direction key presses are ignored, no Alarm: Key1 in a pressurized state, Key2 in a vacuum state, any key during pumping or with a door open.
- Both keys pressed on the same cycle: the valid-direction key wins; the other is ignored.
- Both door switches 1 in an idle state: no transition, Alarm set.

## Timing

- Reset (async assert, sync-released by the system) forces:
  - State=PRESS_IDLE, InnerOpen=0, OuterOpen=0, Pressurized=1, Pumping=0, Alarm=0;
  - counter=0, Key1q=Key2q=1.
- Door response: the switch is sampled on edge N; the door output changes after edge N+1 (one-cycle latency). Close has the same latency.
- Key press seen on edge N: pumping state and Pumping=1 after edge N+1.
- Pump duration: exactly PUMP_CYCLES cycles with Pumping=1 when SW1 stays 0. Each SW1=1 cycle adds one cycle, with Pumping=0 during it.
- Reset mid-pump aborts immediately to PRESS_IDLE, regardless of chamber phase.
- Alarm asserts one cycle after the violating sample.

## Test plan

- Reset, all SW=0, keys=1 → State=0, Pressurized=1, doors 0, Alarm=0. Then SW3=1 → InnerOpen=1 one cycle later; SW3=0 → back to State=0.
- SW0=1, Key2 low for 3 cycles (one press) → Pumping=1 for exactly 5 cycles, then State=3, Pressurized=0. SW2=1 → OuterOpen=1.
- From VAC_IDLE, SW0=1, Key1 press, SW1=1 for 2 cycles mid-pump → Pumping high 5 cycles total across a 7-cycle span, then State=0.
- SW2=1 in PRESS_IDLE → OuterOpen stays 0, Alarm=1 next cycle and persists after SW2=0, until Reset.
- Key2 press with SW0=0, and Key1 press in PRESS_IDLE → no state change, Alarm=0.
- Reset asserted at pump cycle 3 of DEPRESSURIZING → immediately State=0, Pumping=0, Pressurized=1; a new Key2 press restarts a full 5-cycle pump.
